// File: rtl/row_ctrl_pkg.sv
// Shared types and constants for the row_op_ctrl bank sequencer.
//   row_op_e    : row-level operation encoding (matches cmd_op)
//   row_state_e : sequencer FSM states
//   FA_*        : one-hot op_fa encodings broadcast to the row array
//   op_to_fa()  : op -> op_fa one-hot
package row_ctrl_pkg;

   localparam int unsigned OP_W = 2;
   localparam int unsigned FA_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 2'd0,
      OP_AND = 2'd1,
      OP_XOR = 2'd2,
      OP_OR  = 2'd3
   } row_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } row_state_e;

   localparam logic [FA_W-1:0] FA_ADD = 4'b0001;
   localparam logic [FA_W-1:0] FA_AND = 4'b0010;
   localparam logic [FA_W-1:0] FA_XOR = 4'b0100;
   localparam logic [FA_W-1:0] FA_OR  = 4'b1000;

   // Decode an operation into the per-row function-select one-hot.
   function automatic logic [FA_W-1:0] op_to_fa(input row_op_e op);
      logic [FA_W-1:0] fa;
      fa = '0;
      case (op)
         OP_ADD:  fa = FA_ADD;
         OP_AND:  fa = FA_AND;
         OP_XOR:  fa = FA_XOR;
         OP_OR:   fa = FA_OR;
         default: fa = '0;
      endcase
      return fa;
   endfunction

endpackage

// File: rtl/row_onehot_dec.sv
// Row index to one-hot select decoder.
//   idx      : row index (RW bits)
//   en       : decode enable; when low the output is all zero
//   onehot_c : combinational one-hot of idx; indices >= ROWS select no row
module row_onehot_dec
   import row_ctrl_pkg::*;
#(
   parameter  int unsigned ROWS = 8,
   localparam int unsigned RW   = $clog2(ROWS)
) (
   input  logic [RW-1:0]   idx,
   input  logic            en,
   output logic [ROWS-1:0] onehot_c
);

   // Comparing against every row index leaves out-of-range indices unmatched.
   always_comb begin
      onehot_c = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         onehot_c[i] = en && (idx == RW'(i));
      end
   end

endmodule

// File: rtl/row_op_ctrl.sv
// Row-bank sequencer: runs dst = src_a OP src_b as READ -> EXEC -> WRITE -> DONE
// and is the sole driver of the row array's select/enable/op controls.
// Optional feature macro: ROW_OP_CHK_EN (command range / aliasing check).
//   clk, rst            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_op, cmd_cin     : operation and ADD carry-in
//   cmd_src_a/b, dst    : row indices
//   row_ovf             : per-row carry-out from the array
//   rd_sel_up/dn, wr_sel_up/dn, wr_en : one-hot row controls
//   op_fa, first_carry  : broadcast op select and column-0 carry
//   done, ovf           : completion pulse and captured carry-out
//   cmd_err             : reject pulse (ROW_OP_CHK_EN only, else 0)
module row_op_ctrl
   import row_ctrl_pkg::*;
#(
   parameter  int unsigned ROWS   = 8,
   parameter  int unsigned SETTLE = 4,
   localparam int unsigned RW     = $clog2(ROWS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [1:0]      cmd_op,
   input  logic            cmd_cin,
   input  logic [RW-1:0]   cmd_src_a,
   input  logic [RW-1:0]   cmd_src_b,
   input  logic [RW-1:0]   cmd_dst,
   input  logic [ROWS-1:0] row_ovf,
   output logic [ROWS-1:0] rd_sel_up,
   output logic [ROWS-1:0] rd_sel_dn,
   output logic [ROWS-1:0] wr_sel_up,
   output logic [ROWS-1:0] wr_sel_dn,
   output logic [ROWS-1:0] wr_en,
   output logic [3:0]      op_fa,
   output logic            first_carry,
   output logic            done,
   output logic            ovf,
   output logic            cmd_err
);

   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_ADD = CW'(SETTLE - 1);

   row_state_e      state_q, state_n;
   row_op_e         op_q, op_n;
   logic            cin_q, cin_n;
   logic [RW-1:0]   src_a_q, src_a_n;
   logic [RW-1:0]   src_b_q, src_b_n;
   logic [RW-1:0]   dst_q, dst_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic            cap_q, cap_n;

   logic            accept;
   logic            rd_act_n, exec_act_n, wr_act_n;
   logic            cmd_ready_n, first_carry_n, done_n, ovf_n;
   logic [3:0]      op_fa_n;
   logic [ROWS-1:0] rd_up_n, rd_dn_n, wr_up_n, wr_dn_n, wr_en_n;

`ifdef ROW_OP_CHK_EN
   localparam logic [RW:0] ROWS_LIM = (RW + 1)'(ROWS);
   logic cmd_bad;
   logic cmd_err_n;
`endif

   // Next-state, command latch, EXEC counter and carry-out capture.
   always_comb begin
      state_n   = state_q;
      op_n      = op_q;
      cin_n     = cin_q;
      src_a_n   = src_a_q;
      src_b_n   = src_b_q;
      dst_n     = dst_q;
      cnt_n     = cnt_q;
      cap_n     = cap_q;
      accept    = cmd_valid && cmd_ready && (state_q == ST_IDLE);
`ifdef ROW_OP_CHK_EN
      cmd_err_n = 1'b0;
      cmd_bad   = ({1'b0, cmd_src_a} >= ROWS_LIM) ||
                  ({1'b0, cmd_src_b} >= ROWS_LIM) ||
                  ({1'b0, cmd_dst}   >= ROWS_LIM) ||
                  (cmd_dst == cmd_src_b);
`endif

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
`ifdef ROW_OP_CHK_EN
               if (cmd_bad) begin
                  cmd_err_n = 1'b1;
               end else begin
`else
               begin
`endif
                  op_n    = row_op_e'(cmd_op);
                  cin_n   = cmd_cin;
                  src_a_n = cmd_src_a;
                  src_b_n = cmd_src_b;
                  dst_n   = cmd_dst;
                  state_n = ST_READ;
               end
            end
         end
         ST_READ: begin
            cnt_n   = (op_q == OP_ADD) ? CNT_ADD : '0;
            state_n = ST_EXEC;
         end
         ST_EXEC: begin
            if (cnt_q == '0) begin
               // rd_sel_dn holds the src_b one-hot, so an out-of-range src_b captures 0.
               cap_n   = (op_q == OP_ADD) && (|(row_ovf & rd_sel_dn));
               state_n = ST_WRITE;
            end else begin
               cnt_n = cnt_q - CW'(1);
            end
         end
         ST_WRITE: state_n = ST_DONE;
         ST_DONE:  state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   // Output values for the state being entered, registered below.
   always_comb begin
      rd_act_n      = (state_n == ST_READ) || (state_n == ST_EXEC) ||
                      (state_n == ST_WRITE);
      exec_act_n    = (state_n == ST_EXEC) || (state_n == ST_WRITE);
      wr_act_n      = (state_n == ST_WRITE);
      cmd_ready_n   = (state_n == ST_IDLE);
      op_fa_n       = exec_act_n ? op_to_fa(op_n) : '0;
      first_carry_n = exec_act_n && (op_n == OP_ADD) && cin_n;
      done_n        = (state_n == ST_DONE);
      ovf_n         = done_n && cap_n;
   end

   row_onehot_dec #(.ROWS(ROWS)) u_dec_rd_up (.idx(src_a_n), .en(rd_act_n), .onehot_c(rd_up_n));
   row_onehot_dec #(.ROWS(ROWS)) u_dec_rd_dn (.idx(src_b_n), .en(rd_act_n), .onehot_c(rd_dn_n));
   row_onehot_dec #(.ROWS(ROWS)) u_dec_wr_dn (.idx(src_b_n), .en(wr_act_n), .onehot_c(wr_dn_n));
   row_onehot_dec #(.ROWS(ROWS)) u_dec_wr_up (.idx(dst_n),   .en(wr_act_n), .onehot_c(wr_up_n));
   row_onehot_dec #(.ROWS(ROWS)) u_dec_wr_en (.idx(dst_n),   .en(wr_act_n), .onehot_c(wr_en_n));

   // State, command and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_ADD;
         cin_q       <= 1'b0;
         src_a_q     <= '0;
         src_b_q     <= '0;
         dst_q       <= '0;
         cnt_q       <= '0;
         cap_q       <= 1'b0;
         cmd_ready   <= 1'b0;
         rd_sel_up   <= '0;
         rd_sel_dn   <= '0;
         wr_sel_up   <= '0;
         wr_sel_dn   <= '0;
         wr_en       <= '0;
         op_fa       <= '0;
         first_carry <= 1'b0;
         done        <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         state_q     <= state_n;
         op_q        <= op_n;
         cin_q       <= cin_n;
         src_a_q     <= src_a_n;
         src_b_q     <= src_b_n;
         dst_q       <= dst_n;
         cnt_q       <= cnt_n;
         cap_q       <= cap_n;
         cmd_ready   <= cmd_ready_n;
         rd_sel_up   <= rd_up_n;
         rd_sel_dn   <= rd_dn_n;
         wr_sel_up   <= wr_up_n;
         wr_sel_dn   <= wr_dn_n;
         wr_en       <= wr_en_n;
         op_fa       <= op_fa_n;
         first_carry <= first_carry_n;
         done        <= done_n;
         ovf         <= ovf_n;
      end
   end

`ifdef ROW_OP_CHK_EN
   // Reject pulse, one cycle after the refused handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cmd_err <= 1'b0;
      else      cmd_err <= cmd_err_n;
   end
`else
   assign cmd_err = 1'b0;
`endif

endmodule

// File: tb/tb_row_op_ctrl.sv
// Directed, table-driven bench for row_op_ctrl (ROWS=8, SETTLE=4).
module tb_row_op_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic       cmd_cin;
   logic [2:0] cmd_src_a, cmd_src_b, cmd_dst;
   logic [7:0] row_ovf;
   logic [7:0] rd_sel_up, rd_sel_dn, wr_sel_up, wr_sel_dn, wr_en;
   logic [3:0] op_fa;
   logic       first_carry, done, ovf, cmd_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   row_op_ctrl #(.ROWS(8), .SETTLE(4)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_cin(cmd_cin),
      .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
      .row_ovf(row_ovf),
      .rd_sel_up(rd_sel_up), .rd_sel_dn(rd_sel_dn),
      .wr_sel_up(wr_sel_up), .wr_sel_dn(wr_sel_dn), .wr_en(wr_en),
      .op_fa(op_fa), .first_carry(first_carry),
      .done(done), .ovf(ovf), .cmd_err(cmd_err)
   );

   typedef struct {
      logic [1:0] op;
      logic       cin;
      logic [2:0] a, b, d;
      logic [7:0] ovf_rows;
      logic [7:0] up, dn, wup, wdn, wen;
      logic [3:0] fa;
      int         exec;
      logic       fc;
      logic       ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // Issue one command from an IDLE negedge and check every cycle through DONE.
   task automatic run_vec(input vec_t v, input string tag);
      chk({tag, " ready"}, 8'(cmd_ready), 8'h01);
      cmd_valid = 1'b1; cmd_op = v.op; cmd_cin = v.cin;
      cmd_src_a = v.a; cmd_src_b = v.b; cmd_dst = v.d; row_ovf = v.ovf_rows;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({tag, " read up"}, rd_sel_up, v.up);
      chk({tag, " read dn"}, rd_sel_dn, v.dn);
      chk({tag, " read fa"}, 8'(op_fa), 8'h00);
      chk({tag, " read wen"}, wr_en, 8'h00);
      chk({tag, " busy ready"}, 8'(cmd_ready), 8'h00);
      for (int e = 0; e < v.exec; e++) begin
         @(negedge clk);
         chk({tag, " exec fa"}, 8'(op_fa), 8'(v.fa));
         chk({tag, " exec fc"}, 8'(first_carry), 8'(v.fc));
         chk({tag, " exec up"}, rd_sel_up, v.up);
         chk({tag, " exec wen"}, wr_en, 8'h00);
         chk({tag, " exec done"}, 8'(done), 8'h00);
      end
      @(negedge clk);
      chk({tag, " write wen"}, wr_en, v.wen);
      chk({tag, " write wup"}, wr_sel_up, v.wup);
      chk({tag, " write wdn"}, wr_sel_dn, v.wdn);
      chk({tag, " write fa"}, 8'(op_fa), 8'(v.fa));
      chk({tag, " write fc"}, 8'(first_carry), 8'(v.fc));
      chk({tag, " write done"}, 8'(done), 8'h00);
      @(negedge clk);
      chk({tag, " done"}, 8'(done), 8'h01);
      chk({tag, " ovf"}, 8'(ovf), 8'(v.ovf));
      chk({tag, " done wen"}, wr_en, 8'h00);
      chk({tag, " done up"}, rd_sel_up, 8'h00);
      chk({tag, " done fa"}, 8'(op_fa), 8'h00);
      chk({tag, " done fc"}, 8'(first_carry), 8'h00);
      @(negedge clk);
      chk({tag, " done clr"}, 8'(done), 8'h00);
   endtask

   initial begin
      int acc[2], dn[2];
      int na, nd, ready_hi, ndone;
      logic drop;

      //        op   cin a  b  d  ovf_rows up    dn     wup    wdn    wen    fa       ex fc ovf
      vecs[0] = '{2'd0, 1'b0, 3'd1, 3'd2, 3'd3, 8'h04, 8'h02, 8'h04, 8'h08, 8'h04, 8'h08, 4'b0001, 4, 1'b0, 1'b1};
      vecs[1] = '{2'd2, 1'b0, 3'd0, 3'd5, 3'd5, 8'hFF, 8'h01, 8'h20, 8'h20, 8'h20, 8'h20, 4'b0100, 1, 1'b0, 1'b0};
      vecs[2] = '{2'd0, 1'b1, 3'd3, 3'd3, 3'd0, 8'h00, 8'h08, 8'h08, 8'h01, 8'h08, 8'h01, 4'b0001, 4, 1'b1, 1'b0};
      vecs[3] = '{2'd1, 1'b1, 3'd7, 3'd6, 3'd6, 8'h40, 8'h80, 8'h40, 8'h40, 8'h40, 8'h40, 4'b0010, 1, 1'b0, 1'b0};
      vecs[4] = '{2'd3, 1'b0, 3'd2, 3'd4, 3'd2, 8'h10, 8'h04, 8'h10, 8'h04, 8'h10, 8'h04, 4'b1000, 1, 1'b0, 1'b0};
      vecs[5] = '{2'd0, 1'b1, 3'd4, 3'd7, 3'd1, 8'h80, 8'h10, 8'h80, 8'h02, 8'h80, 8'h02, 4'b0001, 4, 1'b1, 1'b1};
      vecs[6] = '{2'd0, 1'b0, 3'd5, 3'd0, 3'd7, 8'hFE, 8'h20, 8'h01, 8'h80, 8'h01, 8'h80, 4'b0001, 4, 1'b0, 1'b0};

      rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_cin = 1'b0;
      cmd_src_a = 3'd0; cmd_src_b = 3'd0; cmd_dst = 3'd0; row_ovf = 8'h00;

      // Reset state
      #3;
      chk("rst ready", 8'(cmd_ready), 8'h00);
      chk("rst up", rd_sel_up, 8'h00);
      chk("rst wen", wr_en, 8'h00);
      chk("rst fa", 8'(op_fa), 8'h00);
      chk("rst done", 8'(done), 8'h00);
      chk("rst err", 8'(cmd_err), 8'h00);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("post-rst ready", 8'(cmd_ready), 8'h01);

      // Table vectors
      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-to-back ADD commands with cmd_valid held
      na = 0; nd = 0; ready_hi = 0; drop = 1'b0;
      acc[0] = -1; acc[1] = -1; dn[0] = -1; dn[1] = -1;
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_cin = 1'b0;
      cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd3; row_ovf = 8'h00;
      for (int c = 0; c < 30; c++) begin
         if (done) begin
            if (nd < 2) dn[nd] = c;
            nd++;
         end
         if (c < 16 && cmd_ready) ready_hi++;
         if (cmd_valid && cmd_ready) begin
            if (na < 2) acc[na] = c;
            na++;
            if (na == 2) drop = 1'b1;
         end
         @(negedge clk);
         if (drop) cmd_valid = 1'b0;
      end
      chk("b2b accepts", 8'(na), 8'd2);
      chk("b2b dones", 8'(nd), 8'd2);
      chk("b2b acc0", 8'(acc[0]), 8'd0);
      chk("b2b done0", 8'(dn[0]), 8'd7);
      chk("b2b acc1", 8'(acc[1]), 8'd8);
      chk("b2b done1", 8'(dn[1]), 8'd15);
      chk("b2b ready cycles", 8'(ready_hi), 8'd2);

      // Reset asserted during EXEC of an ADD with carry-in
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_cin = 1'b1;
      cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd3; row_ovf = 8'h04;
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre-abort fc", 8'(first_carry), 8'h01);
      #2 rst = 1'b0;
      #1;
      chk("abort up", rd_sel_up, 8'h00);
      chk("abort dn", rd_sel_dn, 8'h00);
      chk("abort fa", 8'(op_fa), 8'h00);
      chk("abort fc", 8'(first_carry), 8'h00);
      chk("abort done", 8'(done), 8'h00);
      chk("abort ready", 8'(cmd_ready), 8'h00);
      @(negedge clk);
      rst = 1'b1;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c == 0) chk("abort release ready", 8'(cmd_ready), 8'h01);
         if (done) ndone++;
      end
      chk("abort no done", 8'(ndone), 8'd0);
      run_vec(vecs[3], "post-abort and");

`ifdef ROW_OP_CHK_EN
      // dst aliasing the computing row is refused
      cmd_valid = 1'b1; cmd_op = 2'd1; cmd_cin = 1'b0;
      cmd_src_a = 3'd1; cmd_src_b = 3'd2; cmd_dst = 3'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("chk err", 8'(cmd_err), 8'h01);
      chk("chk ready", 8'(cmd_ready), 8'h01);
      chk("chk up", rd_sel_up, 8'h00);
      ndone = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (c == 0) chk("chk err clr", 8'(cmd_err), 8'h00);
         if (done || (wr_en != 8'h00)) ndone++;
      end
      chk("chk no done", 8'(ndone), 8'd0);
`else
      chk("err tied", 8'(cmd_err), 8'h00);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
